// File: rtl/xbit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xbit_pkg
// Description : Shared types and constants for the CB-prefixed (XBIT) op
//               sequencer: state encoding, op-group codes, shift kinds.
// Revision    : 1.0 - initial release
// ============================================================================
package xbit_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MRD   = 3'd2,
        PASS1 = 3'd3,
        PASS2 = 3'd4,
        WB    = 3'd5,
        MWR   = 3'd6,
        DONE  = 3'd7
    } xbit_state_e;

    // Op group lives in op[7:6] (alu_op[4:3])
    localparam logic [1:0] SHIFT = 2'b00;
    localparam logic [1:0] BIT   = 2'b01;
    localparam logic [1:0] RES   = 2'b10;
    localparam logic [1:0] SET   = 2'b11;

    // Register field value selecting the (HL) memory operand
    localparam logic [2:0] REG_HL = 3'b110;

    // Shift kinds in op[5:3] (alu_op[2:0]); bit 0 set means a right shift
    localparam logic [2:0] SH_RLC = 3'd0;
    localparam logic [2:0] SH_RRC = 3'd1;
    localparam logic [2:0] SH_RL  = 3'd2;
    localparam logic [2:0] SH_RR  = 3'd3;
    localparam logic [2:0] SH_SLA = 3'd4;
    localparam logic [2:0] SH_SRA = 3'd5;
    localparam logic [2:0] SH_SLL = 3'd6;
    localparam logic [2:0] SH_SRL = 3'd7;

    // 1 when the byte holds an even number of ones
    function automatic logic even_parity(input logic [7:0] v);
        return ~(^v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xbit_cin_select.sv
`default_nettype none
// ============================================================================
// Module      : xbit_cin_select
// Description : Picks the shift-in bit and nibble order for the first ALU
//               pass from the latched op, the operand byte and flag C.
// Revision    : 1.0 - initial release
// ============================================================================
module xbit_cin_select
    import xbit_pkg::*;
(
    input  logic [4:0] alu_op,
    input  logic [7:0] operand,
    input  logic       flag_c,
    output logic       first_cin,
    output logic       first_hi
);

    // Right shifts start on the high nibble so the carry ripples downward
    always_comb begin
        first_cin = 1'b0;
        first_hi  = 1'b0;
        if (alu_op[4:3] == SHIFT) begin
            first_hi = alu_op[0];
            case (alu_op[2:0])
                SH_RLC:  first_cin = operand[7];
                SH_RRC:  first_cin = operand[0];
                SH_RL:   first_cin = flag_c;
                SH_RR:   first_cin = flag_c;
                SH_SLA:  first_cin = 1'b0;
                SH_SRA:  first_cin = operand[7];
                SH_SLL:  first_cin = 1'b1;
                SH_SRL:  first_cin = 1'b0;
                default: first_cin = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/xbit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : xbit_sequencer
// Description : Sequences CB-prefixed shift/BIT/RES/SET ops: fetches the op
//               byte, reads the operand (register or (HL)), drives two nibble
//               passes through the shared ALU, writes back and updates flags.
// Revision    : 1.0 - initial release
// ============================================================================
module xbit_sequencer
    import xbit_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       CLK,
    input  logic       notReset,
    input  logic       xbit_start,
    input  logic       flush,
    output logic       op_req,
    input  logic       op_ack,
    input  logic [7:0] op_data,
    output logic       mem_req,
    output logic       mem_we,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_wdata,
    output logic [2:0] reg_sel,
    input  logic [7:0] reg_rdata,
    output logic       reg_we,
    output logic [7:0] reg_wdata,
    output logic [4:0] alu_op,
    output logic       alu_hi,
    output logic [3:0] alu_din,
    output logic       alu_cin,
    input  logic [3:0] alu_dout,
    input  logic       alu_cout,
    input  logic       flag_c_in,
    output logic       flag_we,
    output logic       flag_s,
    output logic       flag_z,
    output logic       flag_pv,
    output logic       flag_c,
    output logic       busy,
    output logic       done,
    output logic       bus_err
);

    localparam int CW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);

    xbit_state_e r_state;
    logic        r_op_req, r_mem_req, r_mem_we, r_reg_we, r_flag_we;
    logic        r_busy, r_done, r_bus_err, r_cin;
    logic        r_flag_s, r_flag_z, r_flag_pv, r_flag_c;
    logic [2:0]  r_reg_sel;
    logic [4:0]  r_alu_op;
    logic [7:0]  r_operand, r_result;
    logic [CW-1:0] r_cnt;

    logic       w_first_cin, w_first_hi, w_in_pass, w_hi, w_timeout;
    logic [1:0] w_group;
    logic [7:0] w_src, w_final;

    assign w_group   = r_alu_op[4:3];
    assign w_in_pass = (r_state == PASS1) || (r_state == PASS2);
    // Register operand is read live during the first pass, then held
    assign w_src     = ((r_state == PASS1) && (r_reg_sel != REG_HL)) ? reg_rdata : r_operand;
    assign w_hi      = (r_state == PASS1) ? w_first_hi :
                       (r_state == PASS2) ? ~w_first_hi : 1'b0;
    assign w_final   = w_hi ? {alu_dout, r_result[3:0]} : {r_result[7:4], alu_dout};
    assign w_timeout = (HOLD_MAX != 0) &&
                       ({{(32-CW){1'b0}}, r_cnt} == (HOLD_MAX - 32'd1));

    xbit_cin_select u_cin_select (
        .alu_op    (r_alu_op),
        .operand   (w_src),
        .flag_c    (flag_c_in),
        .first_cin (w_first_cin),
        .first_hi  (w_first_hi)
    );

    // Main sequencer: state, bus strobes, operand/result latches and flags
    always_ff @(posedge CLK or negedge notReset) begin
        if (!notReset) begin
            r_state   <= IDLE;
            r_op_req  <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_reg_we  <= 1'b0;
            r_flag_we <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bus_err <= 1'b0;
            r_cin     <= 1'b0;
            r_flag_s  <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_pv <= 1'b0;
            r_flag_c  <= 1'b0;
            r_reg_sel <= 3'd0;
            r_alu_op  <= 5'd0;
            r_operand <= 8'd0;
            r_result  <= 8'd0;
            r_cnt     <= '0;
        end else begin
            r_reg_we  <= 1'b0;
            r_flag_we <= 1'b0;
            r_done    <= 1'b0;
            r_bus_err <= 1'b0;
            if (flush) begin
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_op_req  <= 1'b0;
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (xbit_start) begin
                            r_state  <= FETCH;
                            r_busy   <= 1'b1;
                            r_op_req <= 1'b1;
                            r_cnt    <= '0;
                        end
                    end
                    FETCH: begin
                        if (op_ack) begin
                            r_op_req  <= 1'b0;
                            r_reg_sel <= op_data[2:0];
                            r_alu_op  <= op_data[7:3];
                            if (op_data[2:0] == REG_HL) begin
                                r_state   <= MRD;
                                r_mem_req <= 1'b1;
                                r_mem_we  <= 1'b0;
                                r_cnt     <= '0;
                            end else begin
                                r_state <= PASS1;
                            end
                        end else if (w_timeout) begin
                            r_state   <= IDLE;
                            r_busy    <= 1'b0;
                            r_op_req  <= 1'b0;
                            r_bus_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    MRD: begin
                        if (mem_ack) begin
                            r_mem_req <= 1'b0;
                            r_operand <= mem_rdata;
                            r_state   <= PASS1;
                        end else if (w_timeout) begin
                            r_state   <= IDLE;
                            r_busy    <= 1'b0;
                            r_mem_req <= 1'b0;
                            r_bus_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    PASS1: begin
                        r_operand <= w_src;
                        r_result  <= w_final;
                        r_cin     <= alu_cout;
                        r_state   <= PASS2;
                    end
                    PASS2: begin
                        r_result  <= w_final;
                        r_flag_s  <= w_final[7];
                        r_flag_z  <= (w_final == 8'd0);
                        r_flag_pv <= even_parity(w_final);
                        r_flag_c  <= (w_group == SHIFT) ? alu_cout : flag_c_in;
                        if (w_group == BIT) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_flag_we <= 1'b1;
                        end else if (r_reg_sel == REG_HL) begin
                            r_state   <= MWR;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_state  <= WB;
                            r_reg_we <= 1'b1;
                        end
                    end
                    WB: begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_flag_we <= (w_group == SHIFT);
                    end
                    MWR: begin
                        if (mem_ack) begin
                            r_mem_req <= 1'b0;
                            r_mem_we  <= 1'b0;
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_flag_we <= (w_group == SHIFT);
                        end else if (w_timeout) begin
                            r_state   <= IDLE;
                            r_busy    <= 1'b0;
                            r_mem_req <= 1'b0;
                            r_mem_we  <= 1'b0;
                            r_bus_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Write strobes are masked by flush so an abort never lands a write
    assign op_req    = r_op_req;
    assign mem_req   = r_mem_req & ~flush;
    assign mem_we    = r_mem_we  & ~flush;
    assign reg_we    = r_reg_we  & ~flush;
    assign flag_we   = r_flag_we & ~flush;
    assign mem_wdata = r_result;
    assign reg_wdata = r_result;
    assign reg_sel   = r_reg_sel;
    assign alu_op    = r_alu_op;
    assign alu_hi    = w_hi;
    assign alu_din   = w_in_pass ? (w_hi ? w_src[7:4] : w_src[3:0]) : 4'd0;
    assign alu_cin   = (r_state == PASS1) ? w_first_cin :
                       (r_state == PASS2) ? r_cin : 1'b0;
    assign flag_s    = r_flag_s;
    assign flag_z    = r_flag_z;
    assign flag_pv   = r_flag_pv;
    assign flag_c    = r_flag_c;
    assign busy      = r_busy;
    assign done      = r_done;
    assign bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_xbit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbit_sequencer
// Description : Directed bench for xbit_sequencer with an op/memory responder,
//               a small regfile and a behavioural nibble ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbit_sequencer;

    logic       CLK = 1'b0;
    logic       notReset = 1'b0;
    logic       xbit_start = 1'b0, flush = 1'b0;
    logic       op_req, op_ack = 1'b0;
    logic [7:0] op_data = 8'd0;
    logic       mem_req, mem_we, mem_ack = 1'b0;
    logic [7:0] mem_rdata, mem_wdata;
    logic [2:0] reg_sel;
    logic [7:0] reg_rdata;
    logic       reg_we;
    logic [7:0] reg_wdata;
    logic [4:0] alu_op;
    logic       alu_hi;
    logic [3:0] alu_din;
    logic       alu_cin;
    logic [3:0] alu_dout;
    logic       alu_cout;
    logic       flag_c_in = 1'b0;
    logic       flag_we, flag_s, flag_z, flag_pv, flag_c;
    logic       busy, done, bus_err;

    xbit_sequencer #(.HOLD_MAX(4)) dut (
        .CLK(CLK), .notReset(notReset), .xbit_start(xbit_start), .flush(flush),
        .op_req(op_req), .op_ack(op_ack), .op_data(op_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .reg_sel(reg_sel), .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .alu_op(alu_op), .alu_hi(alu_hi), .alu_din(alu_din), .alu_cin(alu_cin),
        .alu_dout(alu_dout), .alu_cout(alu_cout), .flag_c_in(flag_c_in),
        .flag_we(flag_we), .flag_s(flag_s), .flag_z(flag_z), .flag_pv(flag_pv), .flag_c(flag_c),
        .busy(busy), .done(done), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Regfile (read-only image) and memory operand
    logic [7:0] regs [8];
    logic [7:0] mem_val = 8'd0;
    assign reg_rdata = regs[reg_sel];
    assign mem_rdata = mem_val;

    // Nibble ALU: shifts move one bit through cin/cout, bit ops use a mask
    logic [3:0] mask;
    always_comb begin
        mask     = 4'd0;
        alu_dout = 4'd0;
        alu_cout = 1'b0;
        if (alu_op[4:3] == 2'b00) begin
            if (alu_op[0]) begin
                alu_dout = {alu_cin, alu_din[3:1]};
                alu_cout = alu_din[0];
            end else begin
                alu_dout = {alu_din[2:0], alu_cin};
                alu_cout = alu_din[3];
            end
        end else begin
            if (alu_op[2] == alu_hi) mask = 4'b0001 << alu_op[1:0];
            case (alu_op[4:3])
                2'b01:   alu_dout = alu_din & mask;
                2'b10:   alu_dout = alu_din & ~mask;
                default: alu_dout = alu_din | mask;
            endcase
        end
    end

    // Op-byte responder
    logic       op_en = 1'b1;
    logic [7:0] op_val = 8'd0;
    int         ack_cyc = -100;
    initial forever begin
        @(negedge CLK);
        if (op_req && !op_ack && op_en) begin
            op_ack  = 1'b1;
            op_data = op_val;
            ack_cyc = cyc;
        end else begin
            op_ack = 1'b0;
        end
    end

    // Memory responder with programmable wait count
    int         mem_waits = 0, mcnt = 0, n_memwr = 0;
    logic [7:0] mem_wd_cap = 8'd0;
    initial forever begin
        @(negedge CLK);
        if (mem_req && !mem_ack) begin
            if (mcnt >= mem_waits) begin
                mem_ack = 1'b1;
                mcnt    = 0;
                if (mem_we) begin
                    n_memwr++;
                    mem_wd_cap = mem_wdata;
                end
            end else begin
                mcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            mcnt    = 0;
        end
    end

    // Output monitor: cumulative event counts and last captured values
    int         n_regwe = 0, n_flagwe = 0, n_done = 0, n_berr = 0;
    int         done_cyc = 0, berr_cyc = 0;
    logic [7:0] last_wd = 8'd0;
    logic [2:0] last_rs = 3'd0;
    logic [3:0] last_fl = 4'd0;
    logic       first_hi = 1'b0;
    initial forever begin
        @(negedge CLK);
        #1;
        if (reg_we) begin n_regwe++; last_wd = reg_wdata; last_rs = reg_sel; end
        if (flag_we) begin n_flagwe++; last_fl = {flag_s, flag_z, flag_pv, flag_c}; end
        if (done) begin n_done++; done_cyc = cyc; end
        if (bus_err) begin n_berr++; berr_cyc = cyc; end
        if (cyc == ack_cyc + 1) first_hi = alu_hi;
    end

    int n_chk = 0, n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {22'd0, op_req, mem_req, mem_we, reg_sel, reg_we, reg_wdata, mem_wdata,
                alu_op, alu_hi, alu_din, alu_cin, flag_we, flag_s, flag_z, flag_pv,
                flag_c, busy, done, bus_err};
    endfunction

    int b_reg, b_flag, b_done, b_berr, b_mw, start_cyc;

    task automatic snap();
        b_reg  = n_regwe;
        b_flag = n_flagwe;
        b_done = n_done;
        b_berr = n_berr;
        b_mw   = n_memwr;
    endtask

    task automatic kick(input logic [7:0] op);
        snap();
        op_val = op;
        @(negedge CLK);
        xbit_start = 1'b1;
        start_cyc  = cyc;
        @(negedge CLK);
        xbit_start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] op);
        kick(op);
        for (int i = 0; i < 60; i++) begin
            #2;
            if (n_done > b_done || n_berr > b_berr) break;
            @(negedge CLK);
        end
        if (!(n_done > b_done || n_berr > b_berr))
            check_val({tag, "_end"}, 64'd0, 64'd1);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'd0;

        // Reset state
        repeat (3) @(negedge CLK);
        check_val("rst_outs", out_vec(), 64'd0);
        notReset = 1'b1;
        @(negedge CLK);
        check_val("rst_idle", out_vec(), 64'd0);

        // RLC B, B=0x85 -> 0x0B, C=1
        regs[0] = 8'h85; flag_c_in = 1'b0;
        run_op("rlc_b", 8'h00);
        check_val("rlc_we",   n_regwe - b_reg, 1);
        check_val("rlc_sel",  last_rs, 3'd0);
        check_val("rlc_wd",   last_wd, 8'h0B);
        check_val("rlc_c",    last_fl[0], 1'b1);
        check_val("rlc_z",    last_fl[2], 1'b0);
        check_val("rlc_lat",  done_cyc - ack_cyc, 4);
        check_val("rlc_ord",  first_hi, 1'b0);

        // SRA (HL), mem 0x81, two wait states -> 0xC0, S=1 Z=0 PV=1 C=1
        mem_val = 8'h81; mem_waits = 2;
        run_op("sra_hl", 8'h2E);
        check_val("sra_mw",   n_memwr - b_mw, 1);
        check_val("sra_wd",   mem_wd_cap, 8'hC0);
        check_val("sra_fl",   last_fl, 4'b1011);
        check_val("sra_nowe", n_regwe - b_reg, 0);
        mem_waits = 0;

        // BIT 7,A, A=0x7F -> Z=1, no write-back
        regs[7] = 8'h7F;
        run_op("bit7a", 8'h7F);
        check_val("bit_nowe", n_regwe - b_reg, 0);
        check_val("bit_fwe",  n_flagwe - b_flag, 1);
        check_val("bit_z",    last_fl[2], 1'b1);
        check_val("bit_lat",  done_cyc - ack_cyc, 3);

        // SET 0,L, L=0xFE -> 0xFF, no flag write
        regs[5] = 8'hFE;
        run_op("set0l", 8'hC5);
        check_val("set_wd",   last_wd, 8'hFF);
        check_val("set_sel",  last_rs, 3'd5);
        check_val("set_nofw", n_flagwe - b_flag, 0);

        // RR C, C=0x01, carry in 0 -> 0x00, Z=1, C=1, high pass first
        regs[1] = 8'h01; flag_c_in = 1'b0;
        run_op("rr_c", 8'h19);
        check_val("rr_wd",    last_wd, 8'h00);
        check_val("rr_z",     last_fl[2], 1'b1);
        check_val("rr_c",     last_fl[0], 1'b1);
        check_val("rr_ord",   first_hi, 1'b1);

        // RL D, D=0x80, carry in 1 -> 0x01, C=1
        regs[2] = 8'h80; flag_c_in = 1'b1;
        run_op("rl_d", 8'h12);
        check_val("rl_wd",    last_wd, 8'h01);
        check_val("rl_c",     last_fl[0], 1'b1);
        flag_c_in = 1'b0;

        // Flush during the second pass: back to IDLE, nothing written
        regs[3] = 8'h55;
        kick(8'h03);
        for (int i = 0; i < 20; i++) begin
            #2;
            if (ack_cyc >= start_cyc) break;
            @(negedge CLK);
        end
        check_val("fl_ack", (ack_cyc >= start_cyc), 1'b1);
        while (cyc < ack_cyc + 2) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check_val("fl_idle",  busy, 1'b0);
        repeat (6) @(negedge CLK);
        check_val("fl_nowe",  n_regwe - b_reg, 0);
        check_val("fl_nofw",  n_flagwe - b_flag, 0);
        check_val("fl_nodn",  n_done - b_done, 0);

        // Op byte never acknowledged: bus_err 4 cycles after FETCH entry
        op_en = 1'b0;
        run_op("tmo", 8'h00);
        check_val("tmo_err",  n_berr - b_berr, 1);
        check_val("tmo_lat",  berr_cyc - (start_cyc + 1), 4);
        check_val("tmo_busy", busy, 1'b0);
        check_val("tmo_req",  op_req, 1'b0);
        check_val("tmo_nodn", n_done - b_done, 0);
        op_en = 1'b1;

        // Async reset while holding the (HL) write
        mem_val = 8'h03; mem_waits = 3;
        kick(8'h26);
        for (int i = 0; i < 40; i++) begin
            #2;
            if (mem_req && mem_we) break;
            @(negedge CLK);
        end
        check_val("ar_mwr", mem_req && mem_we, 1'b1);
        #2 notReset = 1'b0;
        #1 check_val("ar_outs", out_vec(), 64'd0);
        @(negedge CLK);
        notReset = 1'b1;
        repeat (2) @(negedge CLK);
        check_val("ar_nomw",  n_memwr - b_mw, 0);
        mem_waits = 0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=stuck exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
